// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body held in a circular position buffer, stepped by an FSM.
// Optional border wrapping is built when SNAKE_WRAP_EN is defined.
module snake_body_engine #(
  parameter int X_BITS   = 2,
  parameter int Y_BITS   = 2,
  parameter int MAX_LEN  = 16,
  parameter int INIT_POS = 0,
  localparam int P  = X_BITS + Y_BITS,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int IW = $clog2(MAX_LEN)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    direction,
  input  logic [P-1:0]  apple,
  input  logic          wrap_mode,
  output logic          busy,
  output logic          done,
  output logic          ate,
  output logic          collided,
  output logic          win,
  output logic [LW-1:0] length,
  output logic [P-1:0]  head,
  input  logic [IW-1:0] rd_idx,
  output logic [P-1:0]  rd_pos,
  output logic          rd_valid
);

  localparam int IW1 = IW + 1;
  localparam int MLM1 = MAX_LEN - 1;
  localparam logic [IW:0]   ML   = IW1'(MAX_LEN);
  localparam logic [IW-1:0] LAST = IW'(MLM1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
  localparam logic [P-1:0]  INIT = P'(INIT_POS);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, COMMIT, DONE} state_t;

  state_t        state;
  logic [P-1:0]  body [MAX_LEN];
  logic [IW-1:0] hp, hp_nx, sidx;
  logic [LW-1:0] scan_n;
  logic [1:0]    dir_r;
  logic [P-1:0]  apple_r, nh, nh_r;
  logic          eat, eat_r, ovf, wall;
  logic [X_BITS-1:0] x, nx;
  logic [Y_BITS-1:0] y, ny;

  // Physical slot of segment i: (h - i) mod MAX_LEN, valid for any MAX_LEN.
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] h,
                                         input logic [IW-1:0] i);
    logic [IW:0] t;
    t = {1'b0, h} + ML - {1'b0, i};
    if (t >= ML) t = t - ML;
    return t[IW-1:0];
  endfunction

  assign head  = body[hp];
  assign x     = head[X_BITS-1:0];
  assign y     = head[P-1:X_BITS];
  assign hp_nx = (hp == LAST) ? '0 : hp + IW'(1);

  always_comb begin
    nx  = x;
    ny  = y;
    ovf = 1'b0;
    unique case (dir_r)
      2'b00: begin nx = x + X_BITS'(1); ovf = &x;  end
      2'b01: begin nx = x - X_BITS'(1); ovf = ~|x; end
      2'b10: begin ny = y + Y_BITS'(1); ovf = &y;  end
      2'b11: begin ny = y - Y_BITS'(1); ovf = ~|y; end
    endcase
  end

  assign nh  = {ny, nx};
  assign eat = (nh == apple_r);

`ifdef SNAKE_WRAP_EN
  logic wrap_r;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wrap_r <= 1'b0;
    else if (state == IDLE && step) wrap_r <= wrap_mode;
  end
  assign wall = ovf & ~wrap_r;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_mode;
  assign wall = ovf;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hp       <= '0;
      length   <= LW'(1);
      busy     <= 1'b0;
      done     <= 1'b0;
      ate      <= 1'b0;
      collided <= 1'b0;
      sidx     <= '0;
      scan_n   <= '0;
      dir_r    <= '0;
      apple_r  <= '0;
      nh_r     <= '0;
      eat_r    <= 1'b0;
    end else if (start) begin
      state    <= IDLE;
      hp       <= '0;
      length   <= LW'(1);
      busy     <= 1'b0;
      done     <= 1'b0;
      ate      <= 1'b0;
      collided <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (step) begin
          busy <= 1'b1;
          if (collided) begin
            state <= DONE;
            done  <= 1'b1;
            ate   <= 1'b0;
          end else begin
            dir_r   <= direction;
            apple_r <= apple;
            state   <= CHECK;
          end
        end
        CHECK: begin
          nh_r   <= nh;
          eat_r  <= eat;
          sidx   <= '0;
          // the tail only stays put when the snake grows
          scan_n <= eat ? length : length - LW'(1);
          if (wall) begin
            collided <= 1'b1;
            done     <= 1'b1;
            ate      <= 1'b0;
            state    <= DONE;
          end else if (!eat && length == LW'(1)) begin
            state <= COMMIT;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (body[slot(hp, sidx)] == nh_r) begin
            collided <= 1'b1;
            done     <= 1'b1;
            ate      <= 1'b0;
            state    <= DONE;
          end else if (LW'(sidx) == scan_n - LW'(1)) begin
            state <= COMMIT;
          end else begin
            sidx <= sidx + IW'(1);
          end
        end
        COMMIT: begin
          hp <= hp_nx;
          if (eat_r && length != LMAX) length <= length + LW'(1);
          done  <= 1'b1;
          ate   <= eat_r;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ate   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
      body[0] <= INIT;
    end else if (start) begin
      body[0] <= INIT;
    end else if (state == COMMIT) begin
      body[hp_nx] <= nh_r;
    end
  end

  assign win      = (length == LMAX);
  assign rd_valid = (LW'(rd_idx) < length);
  assign rd_pos   = rd_valid ? body[slot(hp, rd_idx)] : '0;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed and random moves checked against a queue-based
// snake model (head at the front of the queue).
module tb_snake_body_engine;

  localparam int XB = 2, YB = 2, ML = 16, INIT = 0;
  localparam int P = XB + YB, LW = $clog2(ML + 1), IW = $clog2(ML);
  localparam int W = 1 << XB, H = 1 << YB;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_BUILT = 1'b1;
`else
  localparam bit WRAP_BUILT = 1'b0;
`endif

  logic clock = 0, reset = 1, start = 0, step = 0, wrap_mode = 0;
  logic [1:0] direction = '0;
  logic [P-1:0] apple = '0;
  logic [IW-1:0] rd_idx = '0;
  logic busy, done, ate, collided, win, rd_valid;
  logic [LW-1:0] length;
  logic [P-1:0] head, rd_pos;

  snake_body_engine #(.X_BITS(XB), .Y_BITS(YB), .MAX_LEN(ML), .INIT_POS(INIT)) dut (
    .clock(clock), .reset(reset), .start(start), .step(step),
    .direction(direction), .apple(apple), .wrap_mode(wrap_mode),
    .busy(busy), .done(done), .ate(ate), .collided(collided), .win(win),
    .length(length), .head(head), .rd_idx(rd_idx), .rd_pos(rd_pos),
    .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int mbody[$];
  bit mcoll;
  int o_lat, e_lat;
  bit o_ate, o_coll, o_busy, e_ate;

  function automatic int next_cell(int c, int d, bit wr, output bit wall);
    int x = c % W;
    int y = c / W;
    case (d)
      0: x++;
      1: x--;
      2: y++;
      default: y--;
    endcase
    wall = (x < 0 || x >= W || y < 0 || y >= H) && !(wr && WRAP_BUILT);
    x = (x + W) % W;
    y = (y + H) % H;
    return y * W + x;
  endfunction

  task automatic model_start();
    mbody.delete();
    mbody.push_back(INIT);
    mcoll = 0;
  endtask

  task automatic model_step(int d, int a, bit wr, output int lat, output bit e);
    bit wl;
    int nh, n;
    e = 0;
    if (mcoll) begin lat = 1; return; end
    nh = next_cell(mbody[0], d, wr, wl);
    if (wl) begin mcoll = 1; lat = 2; return; end
    e = (nh == a);
    n = e ? mbody.size() : mbody.size() - 1;
    for (int j = 0; j < n; j++)
      if (mbody[j] == nh) begin mcoll = 1; lat = 3 + j; e = 0; return; end
    lat = 3 + n;
    mbody.push_front(nh);
    if (!e || mbody.size() > ML) void'(mbody.pop_back());
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1;
    @(posedge clock);
    #1 start = 0;
    model_start();
  endtask

  task automatic move(int d, int a, bit wr);
    @(negedge clock);
    direction = d[1:0];
    apple = a[P-1:0];
    wrap_mode = wr;
    step = 1;
    @(posedge clock);
    #1 step = 0;
    o_lat = 0;
    o_busy = 0;
    do begin
      @(negedge clock);
      o_lat++;
      if (o_lat == 1) o_busy = busy;
    end while (!done && o_lat < ML + 10);
    o_ate = ate;
    o_coll = collided;
    model_step(d, a, wr, e_lat, e_ate);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
    model_start();
    checks++;
    if (int'(length) !== 1) begin errors++; $display("FAIL reset_length got %0d want 1", length); end
    checks++;
    if (int'(head) !== INIT) begin errors++; $display("FAIL reset_head got %0d want %0d", head, INIT); end
    checks++;
    if ({busy, done, ate, collided, win} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {busy, done, ate, collided, win});
    end
    rd_idx = 0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || int'(rd_pos) !== INIT) begin
      errors++;
      $display("FAIL reset_rd0 got v%b p%0d want v1 p%0d", rd_valid, rd_pos, INIT);
    end
    rd_idx = 1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_pos !== '0) begin
      errors++;
      $display("FAIL reset_rd1 got v%b p%0d want v0 p0", rd_valid, rd_pos);
    end
  endtask

  task automatic test_basic();
    move(0, 5, 0);
    checks++;
    if (o_lat !== 3) begin errors++; $display("FAIL basic_lat got %0d want 3", o_lat); end
    checks++;
    if (int'(head) !== 1 || int'(length) !== 1) begin
      errors++;
      $display("FAIL basic_pos got h%0d l%0d want h1 l1", head, length);
    end
    checks++;
    if (o_ate !== 0 || o_coll !== 0 || o_busy !== 1) begin
      errors++;
      $display("FAIL basic_flags got a%b c%b b%b want a0 c0 b1", o_ate, o_coll, o_busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL basic_pulse got d%b b%b want d0 b0", done, busy);
    end
    move(0, 2, 0);
    checks++;
    if (o_ate !== 1 || int'(length) !== 2 || o_lat !== 4) begin
      errors++;
      $display("FAIL eat_one got a%b l%0d t%0d want a1 l2 t4", o_ate, length, o_lat);
    end
    rd_idx = 0;
    #1;
    checks++;
    if (int'(rd_pos) !== 2) begin errors++; $display("FAIL eat_rd0 got %0d want 2", rd_pos); end
    rd_idx = 1;
    #1;
    checks++;
    if (int'(rd_pos) !== 1) begin errors++; $display("FAIL eat_rd1 got %0d want 1", rd_pos); end
  endtask

  task automatic test_grow();
    int dirs[15] = '{0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0, 2, 1, 1, 1};
    int cells[15] = '{1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};
    do_start();
    for (int i = 0; i < 15; i++) begin
      move(dirs[i], cells[i], 0);
      checks++;
      if (o_ate !== 1 || o_lat !== e_lat || int'(length) !== i + 2) begin
        errors++;
        $display("FAIL grow_%0d got a%b t%0d l%0d want a1 t%0d l%0d",
                 i, o_ate, o_lat, length, e_lat, i + 2);
      end
    end
    checks++;
    if (int'(length) !== ML || win !== 1) begin
      errors++;
      $display("FAIL grow_full got l%0d w%b want l%0d w1", length, win, ML);
    end
    move(3, 8, 0);
    checks++;
    if (o_coll !== 1 || o_lat !== e_lat || int'(length) !== ML || win !== 1 || o_ate !== 0) begin
      errors++;
      $display("FAIL full_eat got c%b t%0d l%0d w%b a%b want c1 t%0d l%0d w1 a0",
               o_coll, o_lat, length, win, o_ate, e_lat, ML);
    end
  endtask

  task automatic test_wall();
    do_start();
    repeat (3) move(0, 15, 0);
    move(0, 15, 0);
    checks++;
    if (o_coll !== 1 || o_lat !== 2 || int'(head) !== 3) begin
      errors++;
      $display("FAIL wall_kill got c%b t%0d h%0d want c1 t2 h3", o_coll, o_lat, head);
    end
    do_start();
    repeat (3) move(0, 15, 1);
    move(0, 15, 1);
    checks++;
    if (o_coll !== mcoll || o_lat !== e_lat || int'(head) !== mbody[0]) begin
      errors++;
      $display("FAIL wall_wrap got c%b t%0d h%0d want c%b t%0d h%0d",
               o_coll, o_lat, head, mcoll, e_lat, mbody[0]);
    end
  endtask

  task automatic test_self_hit();
    int sq[5] = '{5, 6, 2, 1, 0};
    do_start();
    move(0, 1, 0);
    move(0, 2, 0);
    move(2, 6, 0);
    move(1, 5, 0);
    move(3, 15, 0);
    checks++;
    if (o_coll !== 1 || o_lat !== 6 || o_ate !== 0) begin
      errors++;
      $display("FAIL self_hit got c%b t%0d a%b want c1 t6 a0", o_coll, o_lat, o_ate);
    end
    for (int i = 0; i < 5; i++) begin
      rd_idx = i[IW-1:0];
      #1;
      checks++;
      if (int'(rd_pos) !== sq[i]) begin
        errors++;
        $display("FAIL self_body_%0d got %0d want %0d", i, rd_pos, sq[i]);
      end
    end
    move(0, 15, 0);
    checks++;
    if (o_lat !== 1 || int'(head) !== 5 || int'(length) !== 5 || collided !== 1) begin
      errors++;
      $display("FAIL dead_step got t%0d h%0d l%0d c%b want t1 h5 l5 c1",
               o_lat, head, length, collided);
    end
  endtask

  task automatic test_tail();
    do_start();
    move(0, 1, 0);
    move(1, 15, 0);
    checks++;
    if (o_coll !== 0 || o_lat !== 4 || int'(head) !== 0 || int'(length) !== 2) begin
      errors++;
      $display("FAIL tail_vacate got c%b t%0d h%0d l%0d want c0 t4 h0 l2",
               o_coll, o_lat, head, length);
    end
    move(0, 1, 0);
    checks++;
    if (o_coll !== 1 || o_lat !== 4 || o_ate !== 0) begin
      errors++;
      $display("FAIL tail_eat got c%b t%0d a%b want c1 t4 a0", o_coll, o_lat, o_ate);
    end
  endtask

  task automatic test_abort();
    int seen;
    do_start();
    move(0, 1, 0);
    move(0, 2, 0);
    @(negedge clock);
    direction = 2'b10;
    apple = 4'd15;
    step = 1;
    @(posedge clock);
    #1 step = 0;
    @(negedge clock);
    @(negedge clock);
    start = 1;
    @(posedge clock);
    #1 start = 0;
    model_start();
    checks++;
    if (int'(length) !== 1 || int'(head) !== INIT || busy !== 0) begin
      errors++;
      $display("FAIL start_abort got l%0d h%0d b%b want l1 h%0d b0", length, head, busy, INIT);
    end
    seen = 0;
    repeat (6) begin @(negedge clock); if (done) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL start_nodone got %0d want 0", seen); end
    move(0, 1, 0);
    @(negedge clock);
    direction = 2'b01;
    apple = 4'd15;
    step = 1;
    @(posedge clock);
    #1 step = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    #1;
    checks++;
    if (int'(length) !== 1 || int'(head) !== INIT || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_abort got l%0d h%0d b%b d%b want l1 h%0d b0 d0",
               length, head, busy, done, INIT);
    end
    @(negedge clock);
    reset = 0;
    model_start();
    seen = 0;
    repeat (6) begin @(negedge clock); if (done) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_nodone got %0d want 0", seen); end
  endtask

  task automatic test_random();
    int d, a, nh, ev;
    bit wr, wl, evv;
    do_start();
    for (int it = 0; it < 200; it++) begin
      if (mcoll && $urandom_range(0, 2) != 0) do_start();
      d = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      nh = next_cell(mbody[0], d, wr, wl);
      a = $urandom_range(0, 1) ? nh : $urandom_range(0, W * H - 1);
      move(d, a, wr);
      checks++;
      if (o_lat !== e_lat || o_ate !== e_ate || o_coll !== mcoll) begin
        errors++;
        $display("FAIL rnd_%0d_move got t%0d a%b c%b want t%0d a%b c%b",
                 it, o_lat, o_ate, o_coll, e_lat, e_ate, mcoll);
      end
      checks++;
      if (int'(length) !== mbody.size() || int'(head) !== mbody[0] ||
          win !== (mbody.size() == ML)) begin
        errors++;
        $display("FAIL rnd_%0d_state got l%0d h%0d w%b want l%0d h%0d",
                 it, length, head, win, mbody.size(), mbody[0]);
      end
      for (int i = 0; i < ML; i++) begin
        rd_idx = i[IW-1:0];
        #1;
        evv = (i < mbody.size());
        ev = evv ? mbody[i] : 0;
        checks++;
        if (rd_valid !== evv || int'(rd_pos) !== ev) begin
          errors++;
          $display("FAIL rnd_%0d_rd%0d got v%b p%0d want v%b p%0d",
                   it, i, rd_valid, rd_pos, evv, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grow();
    test_wall();
    test_self_hit();
    test_tail();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake movement engine for the Snake Game Arcade datapath. It holds the snake body in a circular position buffer, replacing the shift-through RAM. On each `step` request it computes the new head, checks walls (or wraps), scans the body for self-collision and detects apple capture. It then either grows or advances the snake. The block sits between the game control unit (which issues `step`/`start` and consumes `done`/`ate`/`collided`) and the LED-matrix renderer (which reads segments through the read port).

## Interface
- `X_BITS`, 2, column coordinate width.
- `Y_BITS`, 2, row coordinate width. Position width P = X_BITS+Y_BITS, encoded {y, x}.
- `MAX_LEN`, 16, body capacity in segments. Must satisfy 2 ≤ MAX_LEN ≤ 2^P. Need not be a power of two.
- `INIT_POS`, 0, head position after reset/`start`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  synchronous reinitialise: length 1, head `INIT_POS`, flags cleared.
- `step`  in  1  one-cycle move request.
- `direction`  in  2  00 x+1, 01 x−1, 10 y+1, 11 y−1. Sampled with `step`.
- `apple`  in  P  apple position. Sampled with `step`.
- `wrap_mode`  in  1  1 = borders wrap, 0 = borders kill. Sampled with `step`.
- `busy`  out  1  high from the cycle after `step` acceptance until `done`.
- `done`  out  1  one-cycle pulse when a move completes.
- `ate`  out  1  qualified by `done`: new head equalled `apple`.
- `collided`  out  1  sticky; wall or self collision occurred.
- `win`  out  1  length == MAX_LEN.
- `length`  out  clog2(MAX_LEN+1)  current segment count.
- `head`  out  P  current head position.
- `rd_idx`  in  clog2(MAX_LEN)  render index (0 = head).
- `rd_pos`  out  P  combinational segment position; 0 when rd_idx ≥ length.
- `rd_valid`  out  1  rd_idx < length.

## Operation
- Storage: MAX_LEN×P register buffer, head pointer `hp`, pointer arithmetic explicitly modulo MAX_LEN. Segment i sits at buf[(hp − i) mod MAX_LEN].
- FSM states are IDLE, CHECK, SCAN, COMMIT, DONE.
  - IDLE: accepts `step` when `collided`=0 and goes to CHECK. With `collided`=1, `step` goes straight to DONE and the body is unchanged.
  - CHECK computes new head `nh`. An x or y over/underflow is a wall hit when wrap is off; with wrap on, the coordinate wraps modulo 2^X_BITS or 2^Y_BITS. It also computes `eat` = (nh == sampled apple).
    - A wall hit sets `collided` and goes to DONE.
    - Otherwise it goes to SCAN with scan count N = length−1 if `eat`=0, else length. The tail segment is excluded when it will vacate.
    - If N = 0, it goes to COMMIT directly.
  - SCAN compares `nh` with one segment per cycle, index 0 to N−1. A match sets `collided` and goes to DONE. It goes to COMMIT after the last compare.
  - COMMIT: hp ← hp+1, buf[hp+1] ← nh.
    - If `eat` and length < MAX_LEN, length increments.
    - Otherwise length is unchanged, so the tail drops implicitly.
    - Eating at MAX_LEN therefore does not grow the snake, and `win` stays 1.
  - DONE asserts `done`=1. `ate` = `eat` if no collision, else 0. Returns to IDLE.
- `step` outside IDLE is ignored, with no queueing.
- `start` has priority over `step` and `reset`-free operation in every state.
  - Next cycle: IDLE, length 1, hp 0, buf[0] = INIT_POS, `collided` 0.
  - Any move in flight is aborted with no `done`.
- Reset values: state IDLE, length 1, `head` = INIT_POS, `busy`/`done`/`ate`/`collided`/`win` 0.

## Timing
- `step` sampled at edge k, IDLE. CHECK in cycle k+1, SCAN in cycles k+2…k+1+N, COMMIT at k+2+N, `done` high during cycle k+3+N.
- Wall hit: `done` in cycle k+2. Self hit at scan index j: `done` in cycle k+3+j.
- Collided-state step: `done` in cycle k+1.
- `head`, `length` and `win` update on the COMMIT edge and are valid when `done` is high.
- Read port is purely combinational from `rd_idx` and current state. It is stable except on the COMMIT edge.
- Worst-case latency is MAX_LEN+3 cycles.

## Configuration
- `SNAKE_WRAP_EN` defined: wrap logic is built and `wrap_mode` selects behaviour as above.
- Not defined: `wrap_mode` is ignored (port kept, unused) and every border crossing is a wall collision.

## Test plan
- Reset, then `step` dir 00 with apple 5 from head 0: `done` at k+3, head 1, length 1, `ate` 0, `collided` 0.
- Head 1, apple 2, step dir 00: `ate` 1, length 2, `rd_pos` for idx 0/1 = 2/1. Repeat 15 eats: length saturates at 16, `win` 1.
- Head x=3, dir 00: without the macro, `collided` 1 and `done` at k+2. With the macro and `wrap_mode`=1, the new head has x=0 and no collision.
- Length 5 body forming a square: turn into own segment 3 → `collided` 1 at `done`, body unchanged. A further `step` gives `done` next cycle and nothing changes.
- Length 2, move into the current tail cell: no collision, because the tail vacates. Same move with apple on that cell: collision.
- `start` during SCAN: no `done`, next cycle length 1, head INIT_POS, `busy` 0. Async `reset` mid-move behaves the same, taking effect immediately.
